// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle ARM datapath and its main controller.
// The datapath side presents the IR fields and ALU flags; the controller
// returns the per-cycle steering and enable signals.
interface multicycle_controller_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [1:0] RegSrc;
  logic [1:0] ALUControl;

  // datapath side
  modport master (
    output Cond, Op, Funct, Rd, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl
  );

  // controller side
  modport slave (
    input  Cond, Op, Funct, Rd, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main control unit of the multicycle ARM datapath: Moore FSM with registered
// outputs, NZCV flag register and condition evaluation in DECODE.
module multicycle_controller (
  input  logic                   clk,
  input  logic                   rst,   // active-low, asynchronous
  multicycle_controller_if.slave bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_control;
  } ctrl_t;

  localparam ctrl_t FETCH_CTRL = '{pc_write: 1'b1, adr_src: 1'b0, mem_write: 1'b0,
                                   ir_write: 1'b1, reg_write: 1'b0, result_src: 2'b10,
                                   alu_src_a: 1'b1, alu_src_b: 2'b10, alu_control: 2'b00};

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       cond_ex;

  // IR field aliases
  logic [3:0] cmd;
  logic       i_bit, u_bit, s_bit, l_bit, rd_pc;
  logic       is_cmp, arith, dp_ok, supported;
  logic [1:0] alu_ctl;

  assign cmd    = bus.Funct[4:1];
  assign i_bit  = bus.Funct[5];
  assign u_bit  = bus.Funct[3];
  assign s_bit  = bus.Funct[0];
  assign l_bit  = bus.Funct[0];
  assign rd_pc  = (bus.Rd == 4'b1111);
  assign is_cmp = (cmd == 4'b1010);

  // Data-processing command decode: ALU op, whether C/V are meaningful, legality
  always_comb begin
    alu_ctl = 2'b00;
    arith   = 1'b0;
    dp_ok   = 1'b1;
    case (cmd)
      4'b0100: begin alu_ctl = 2'b00; arith = 1'b1; end
      4'b0010: begin alu_ctl = 2'b01; arith = 1'b1; end
      4'b1010: begin alu_ctl = 2'b01; arith = 1'b1; end
      4'b0000: alu_ctl = 2'b10;
      4'b1100: alu_ctl = 2'b11;
      default: dp_ok = 1'b0;
    endcase
  end

  assign supported = (bus.Op == 2'b01) || (bus.Op == 2'b10) || (bus.Op == 2'b00 && dp_ok);

  // ARM condition check against the registered flags {N,Z,C,V}
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags_q;
    cond_ex = 1'b0;
    case (bus.Cond)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Next state, flag update, and the controls of the state being entered
  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        if (!cond_ex || !supported) state_d = FETCH;
        else if (bus.Op == 2'b01)   state_d = MEMADR;
        else if (bus.Op == 2'b10)   state_d = BRANCH;
        else                        state_d = i_bit ? EXECUTEI : EXECUTER;
      end
      MEMADR: state_d = l_bit ? MEMRD : MEMWR;
      MEMRD:  state_d = MEMWB;
      EXECUTER, EXECUTEI: begin
        state_d = ALUWB;
        if (s_bit && cond_ex) begin
          flags_d[3:2] = bus.ALUFlags[3:2];
          if (arith) flags_d[1:0] = bus.ALUFlags[1:0];
        end
      end
      default: state_d = FETCH;
    endcase

    ctrl_d = '0;
    case (state_d)
      FETCH:  ctrl_d = FETCH_CTRL;
      DECODE: begin
        ctrl_d.alu_src_a  = 1'b1;
        ctrl_d.alu_src_b  = 2'b10;
        ctrl_d.result_src = 2'b10;
      end
      MEMADR: begin
        ctrl_d.alu_src_b   = 2'b01;
        ctrl_d.alu_control = u_bit ? 2'b00 : 2'b01;
      end
      MEMRD: ctrl_d.adr_src = 1'b1;
      MEMWB: begin
        ctrl_d.result_src = 2'b01;
        ctrl_d.pc_write   = rd_pc;
        ctrl_d.reg_write  = ~rd_pc;
      end
      MEMWR: begin
        ctrl_d.adr_src   = 1'b1;
        ctrl_d.mem_write = 1'b1;
      end
      EXECUTER: ctrl_d.alu_control = alu_ctl;
      EXECUTEI: begin
        ctrl_d.alu_src_b   = 2'b01;
        ctrl_d.alu_control = alu_ctl;
      end
      ALUWB: begin
        ctrl_d.pc_write  = ~is_cmp & rd_pc;
        ctrl_d.reg_write = ~is_cmp & ~rd_pc;
      end
      BRANCH: begin
        ctrl_d.alu_src_b  = 2'b01;
        ctrl_d.result_src = 2'b10;
        ctrl_d.pc_write   = 1'b1;
      end
      default: ctrl_d = '0;
    endcase
  end

  // State, flags and output registers; reset parks everything in FETCH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      flags_q <= 4'b0000;
      ctrl_q  <= FETCH_CTRL;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // Write enables are masked by reset so an abandoned write stops at once
  assign bus.PCWrite    = ctrl_q.pc_write  & rst;
  assign bus.IRWrite    = ctrl_q.ir_write  & rst;
  assign bus.RegWrite   = ctrl_q.reg_write & rst;
  assign bus.MemWrite   = ctrl_q.mem_write & rst;
  assign bus.AdrSrc     = ctrl_q.adr_src;
  assign bus.ResultSrc  = ctrl_q.result_src;
  assign bus.ALUSrcA    = ctrl_q.alu_src_a;
  assign bus.ALUSrcB    = ctrl_q.alu_src_b;
  assign bus.ALUControl = ctrl_q.alu_control;

  // Immediate and register-source steering follow the instruction class
  assign bus.ImmSrc = (bus.Op == 2'b11) ? 2'b00 : bus.Op;
  assign bus.RegSrc = {(bus.Op == 2'b01) && !l_bit, (bus.Op == 2'b10)};

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control unit for the multicycle ARM datapath. It decodes the instruction held in the instruction register and steps a Moore state machine through fetch, decode, execute and writeback, one datapath operation per cycle. It evaluates the condition field against its own registered NZCV flags and gates every architectural write with the result. It drives the PC, IR, register file, memory and ALU steering controls of the shared-memory multicycle datapath.

## Interface
Parameters: none.
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- Cond  input  4  IR[31:28]
- Op  input  2  IR[27:26]
- Funct  input  6  IR[25:20] (I, cmd[3:0], S; for memory ops Funct[3]=U, Funct[0]=L)
- Rd  input  4  IR[15:12]
- ALUFlags  input  4  {N,Z,C,V} from the ALU, current cycle
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address: 0=PC, 1=Result
- MemWrite  output  1  data memory write enable
- IRWrite  output  1  instruction register enable
- RegWrite  output  1  register file write enable
- ResultSrc  output  2  00=ALUOut, 01=read data, 10=ALUResult
- ALUSrcA  output  1  0=register A, 1=PC
- ALUSrcB  output  2  00=register B, 01=ExtImm, 10=constant 4
- ImmSrc  output  2  00=imm8, 01=imm12, 10=imm24 branch
- RegSrc  output  2  [0]=1 reads Rn as R15 (branch); [1]=1 reads Rd as RB (STR)
- ALUControl  output  2  00=ADD, 01=SUB, 10=AND, 11=ORR

## Operation
- Supported instructions:
  - Data processing (Op=00) with cmd ADD 0100, SUB 0010, AND 0000, ORR 1100, and CMP 1010. CMP forces a SUB and never writes a register.
  - LDR/STR (Op=01) with immediate offset. U=1 adds the offset, U=0 subtracts it.
  - B (Op=10).
- Unsupported encodings (Op=11, other cmd values) execute as a NOP.
- CondEx is combinational from Cond and the flag register: EQ NE CS CC MI PL VS VC HI LS GE LT GT LE AL per ARM; Cond=1111 gives CondEx=0.
- Flag register: 4 bits, reset 0000.
  - Written only on the edge leaving EXECUTER/EXECUTEI, and only when S=1 and CondEx=1.
  - N and Z are always written.
  - C and V are written only for ADD, SUB and CMP.
- States and outputs:
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10, PCWrite=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=00 if U=1, 01 if U=0.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWR: AdrSrc=1, MemWrite=1.
  - EXECUTER: ALUSrcA=0, ALUSrcB=00, ALUControl per cmd.
  - EXECUTEI: ALUSrcA=0, ALUSrcB=01, ALUControl per cmd.
  - ALUWB: ResultSrc=00, RegWrite=1 unless CMP.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ALUControl=00, ResultSrc=10, PCWrite=1.
  - Every output not listed for a state is 0.
- Output decoding that applies in every state:
  - ImmSrc and RegSrc are decoded from Op alone.
  - RegSrc[1]=1 only for STR.
- Writeback to R15: in MEMWB or ALUWB with Rd=1111, PCWrite=1 replaces RegWrite.
- Transitions:
  - FETCH→DECODE.
  - DECODE→FETCH if CondEx=0 or the encoding is unsupported. Otherwise:
    - Op=01 → MEMADR.
    - Op=10 → BRANCH.
    - Op=00 with I=0 → EXECUTER.
    - Op=00 with I=1 → EXECUTEI.
  - MEMADR→MEMRD if L=1, MEMWR if L=0.
  - MEMRD→MEMWB.
  - EXECUTER/EXECUTEI→ALUWB.
  - MEMWB, MEMWR, ALUWB and BRANCH→FETCH.
- State encoding: binary, 4 bits.

## Timing
- Asserting rst immediately forces state FETCH and flags 0000.
- While rst=0, PCWrite, IRWrite, RegWrite and MemWrite are 0. All other outputs hold their FETCH values.
- The first FETCH edge occurs on the first rising clk after rst deasserts.
- Reset mid-instruction abandons the instruction; a partial write never completes.
- Cycles per instruction: B=3, data processing=4, STR=4, LDR=5, condition-failed/NOP=2.
- CondEx is evaluated in DECODE only. A flag update by the current instruction does not affect its own writes.
- Outputs are purely state-decoded (Moore). The IR must be stable from DECODE onward.

## Test plan
- Reset then release → FETCH outputs with PCWrite=1 and IRWrite=1 on the first cycle; DECODE next; flags=0000.
- ADD with S=1, I=1, ALUFlags=0110 in EXECUTEI → states FETCH, DECODE, EXECUTEI, ALUWB; RegWrite=1 in ALUWB only; flags=0110 afterwards.
- LDR with U=0, Rd=1111 → MEMADR has ALUControl=01; MEMRD has AdrSrc=1; MEMWB has PCWrite=1 and RegWrite=0; 5 cycles total.
- STR → RegSrc=1x throughout; MemWrite=1 only in MEMWR; 4 cycles.
- Sequence "CMP (ALUFlags=0100), then BEQ, then BNE" → flags Z=1; BEQ takes BRANCH with PCWrite=1 (3 cycles); BNE returns to FETCH after DECODE (2 cycles).
- rst asserted during MEMWR → MemWrite drops to 0 immediately; FETCH after release; Cond=1111 and Op=11 each complete as 2-cycle NOPs.
